decoder_2to4: RTL and testbench

DECODER_2TO4 -- requirements
Module: decoder_2to4

---
 rtl/decoder_2to4_pkg.sv | 26 ++
 rtl/sat_counter.sv | 22 ++
 rtl/decoder_2to4.sv | 61 ++++++
 tb/tb_decoder_2to4.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/decoder_2to4_pkg.sv
// Shared constants and the one-hot decode used by decoder_2to4.
package decoder_2to4_pkg;

    localparam int DEC_W = 2;
    localparam int OUT_W = 4;

    // An X select with en low must still decode to zero, so en gates first.
    function automatic logic [OUT_W-1:0] decode_onehot(
        input logic [DEC_W-1:0] sel,
        input logic             en
    );
        logic [OUT_W-1:0] y;
        y = '0;
        if (en) begin
            case (sel)
                2'd0:    y = 4'b0001;
                2'd1:    y = 4'b0010;
                2'd2:    y = 4'b0100;
                2'd3:    y = 4'b1000;
                default: y = '0;
            endcase
        end
        return y;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/decoder_2to4.sv
// 2-to-4 one-hot decoder with optional output register and
// per-output saturating activation counters.
module decoder_2to4
    import decoder_2to4_pkg::*;
#(
    parameter int OUT_REG = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DEC_W-1:0] a,
    input  logic             en,
    input  logic             clr,
    input  logic [DEC_W-1:0] cnt_sel,
    output logic [OUT_W-1:0] y,
    output logic             y_valid,
    output logic [CNT_W-1:0] cnt
);

    logic [OUT_W-1:0] y_d;
    logic [CNT_W-1:0] cnt_q [OUT_W];

    assign y_d = decode_onehot(a, en);

    if (OUT_REG != 0) begin : g_reg
        logic [OUT_W-1:0] y_q;
        logic             v_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                y_q <= '0;
                v_q <= 1'b0;
            end else begin
                y_q <= y_d;
                v_q <= en;
            end
        end

        assign y       = y_q;
        assign y_valid = v_q;
    end else begin : g_comb
        // Reset still forces the outputs low in combinational mode.
        assign y       = rst_n ? y_d : '0;
        assign y_valid = rst_n & en;
    end

    for (genvar i = 0; i < OUT_W; i++) begin : g_cnt
        sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (y_d[i]),
            .clr   (clr),
            .cnt   (cnt_q[i])
        );
    end

    assign cnt = cnt_q[cnt_sel];

endmodule

// File: tb/tb_decoder_2to4.sv
// Directed and random self-checking bench for decoder_2to4.
module tb_decoder_2to4;

    logic       clk;
    logic       rst_n;
    logic [1:0] a;
    logic       en;
    logic       clr;
    logic [1:0] cnt_sel;
    logic [3:0] y;
    logic       y_valid;
    logic [7:0] cnt;

    int checks;
    int errors;
    int cnt_m [4];

    decoder_2to4 #(
        .OUT_REG (1),
        .CNT_W   (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .en      (en),
        .clr     (clr),
        .cnt_sel (cnt_sel),
        .y       (y),
        .y_valid (y_valid),
        .cnt     (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string tag, input logic [1:0] sel,
                             input int exp);
        cnt_sel = sel;
        #1;
        check(tag, {24'd0, cnt}, exp);
    endtask

    initial begin
        logic [3:0] exp_y;
        logic [1:0] ra;
        logic       ren;

        checks  = 0;
        errors  = 0;
        rst_n   = 1'b1;
        en      = 1'b1;
        a       = 2'd3;
        clr     = 1'b0;
        cnt_sel = 2'd3;

        // Asynchronous reset before any clock edge.
        #3 rst_n = 1'b0;
        #1;
        check("rst_y", {28'd0, y}, 0);
        check("rst_valid", {31'd0, y_valid}, 0);
        check("rst_cnt", {24'd0, cnt}, 0);

        tick();
        tick();
        check("rst_hold_y", {28'd0, y}, 0);
        en    = 1'b0;
        rst_n = 1'b1;
        tick();
        check("post_rst_y", {28'd0, y}, 0);
        check("post_rst_valid", {31'd0, y_valid}, 0);

        // Sweep all select codes.
        for (int i = 0; i < 4; i++) begin
            a  = 2'(i);
            en = 1'b1;
            tick();
            exp_y = 4'b0001 << i;
            check("sweep_y", {28'd0, y}, {28'd0, exp_y});
            check("sweep_valid", {31'd0, y_valid}, 1);
        end
        for (int i = 0; i < 4; i++)
            check_cnt("sweep_cnt", 2'(i), 1);

        // Disable.
        en = 1'b0;
        a  = 2'd2;
        tick();
        check("dis_y", {28'd0, y}, 0);
        check("dis_valid", {31'd0, y_valid}, 0);
        check_cnt("dis_cnt2", 2'd2, 1);

        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 4; i++)
            check_cnt("clr_cnt", 2'(i), 0);

        // Count five activations of output 1.
        en = 1'b1;
        a  = 2'd1;
        repeat (5) tick();
        en = 1'b0;
        check_cnt("cnt1_5", 2'd1, 5);
        check_cnt("cnt0_0", 2'd0, 0);

        // Saturation at 255.
        en = 1'b1;
        a  = 2'd3;
        repeat (254) tick();
        check_cnt("sat_254", 2'd3, 254);
        tick();
        check_cnt("sat_255", 2'd3, 255);
        repeat (45) tick();
        check_cnt("sat_hold", 2'd3, 255);

        // Clear wins over a simultaneous increment.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_pri_y", {28'd0, y}, 4'b1000);
        check_cnt("clr_pri_cnt", 2'd3, 0);

        // Reset mid-operation drops the pending one-hot.
        a = 2'd2;
        tick();
        check("mid_y", {28'd0, y}, 4'b0100);
        rst_n = 1'b0;
        #1;
        check("mid_rst_y", {28'd0, y}, 0);
        check("mid_rst_valid", {31'd0, y_valid}, 0);
        check_cnt("mid_rst_cnt", 2'd2, 0);
        tick();
        en    = 1'b0;
        rst_n = 1'b1;
        tick();
        check("no_stale_y", {28'd0, y}, 0);

        // Undefined select with en low.
        a  = 2'bxx;
        en = 1'b0;
        tick();
        check("x_sel_y", {28'd0, y}, 0);
        check("x_sel_valid", {31'd0, y_valid}, 0);
        for (int i = 0; i < 4; i++)
            check_cnt("x_sel_cnt", 2'(i), 0);

        // Random traffic against a small reference model.
        for (int i = 0; i < 4; i++) cnt_m[i] = 0;
        for (int n = 0; n < 1000; n++) begin
            ra      = 2'($urandom_range(0, 3));
            ren     = 1'($urandom_range(0, 1));
            a       = ra;
            en      = ren;
            cnt_sel = 2'($urandom_range(0, 3));
            #1;
            check("rnd_cnt", {24'd0, cnt}, cnt_m[cnt_sel]);
            tick();
            if (ren && cnt_m[ra] < 255) cnt_m[ra]++;
            exp_y = ren ? (4'b0001 << ra) : 4'b0000;
            check("rnd_y", {28'd0, y}, {28'd0, exp_y});
            check("rnd_valid", {31'd0, y_valid}, {31'd0, ren});
            check("rnd_onehot", {31'd0, $onehot0(y)}, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
